lzy_mux4_arbiter: RTL and testbench

//  Round-robin arbiter sharing one lzy_74HC153 4-to-1 mux among 4 requesters.

---
 rtl/lzy_arb_pkg.sv | 20 ++
 rtl/lzy_rr_pick4.sv | 34 +++
 rtl/lzy_mux4_arbiter.sv | 95 +++++++++
 tb/tb_lzy_mux4_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lzy_arb_pkg.sv
// Shared definitions for the 4-channel round-robin mux arbiter.
//   N_CH             number of requesting channels
//   ST_IDLE/GRANT/GAP  arbiter state encoding
//   onehot4()        index -> one-hot grant vector
package lzy_arb_pkg;

  localparam int N_CH = 4;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  function automatic logic [N_CH-1:0] onehot4(input logic [1:0] idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lzy_rr_pick4.sv
// Combinational round-robin picker.
//   req   in  4  request vector
//   ptr   in  2  last served channel; search starts at ptr+1
//   idx   out 2  first requesting channel found, wrapping mod 4
//   valid out 1  at least one request present
module lzy_rr_pick4
  import lzy_arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      idx,
  output logic            valid
);

  logic [1:0] cand;

  // Walk from lowest priority (ptr itself) to highest (ptr+1) so the last
  // hit written is the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional write, otherwise synthesis infers a latch.
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = N_CH; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzy_mux4_arbiter.sv
// Round-robin arbiter that shares one 74HC153 4:1 mux among 4 requesters.
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous reset, active-high
//   req    in   4  per-channel request, held while the channel wants the mux
//   gnt    out  4  one-hot grant, registered
//   mux_e  out  1  mux enable, active-low (1 forces Y low), registered
//   mux_s  out  2  mux select = granted channel, registered
//   busy   out  1  arbiter not idle
// A grant lasts until the owner drops req, or until its slot of SLOT_CYCLES
// cycles has elapsed while another channel waits. Every handoff passes
// through exactly one GAP cycle with the mux disabled (break-before-make).
module lzy_mux4_arbiter
  import lzy_arb_pkg::*;
#(
  parameter int SLOT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt,
  output logic            mux_e,
  output logic [1:0]      mux_s,
  output logic            busy
);

  localparam int              CW        = $clog2(SLOT_CYCLES + 1);
  localparam logic [CW-1:0]   SLOT_LOAD = CW'(SLOT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    ptr;

  logic [1:0]    pick_idx;
  logic          pick_valid;
  logic          owner_release;
  logic          owner_preempt;

  // In GAP, ptr already holds the channel just served, so the same picker
  // serves both the IDLE and the GAP arbitration.
  lzy_rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign owner_release = ~req[mux_s];
  assign owner_preempt = (cnt == '0) && ((req & ~gnt) != '0);

  assign busy = (state != ST_IDLE);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      mux_e <= 1'b1;
      mux_s <= 2'b00;
      cnt   <= '0;
      ptr   <= 2'd3;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (pick_valid) begin
            state <= ST_GRANT;
            gnt   <= onehot4(pick_idx);
            mux_s <= pick_idx;
            mux_e <= 1'b0;
            cnt   <= SLOT_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (owner_release || owner_preempt) begin
            // mux_s is kept so the disabled mux still points at the last owner.
            state <= ST_GAP;
            gnt   <= '0;
            mux_e <= 1'b1;
            ptr   <= mux_s;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          mux_e <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzy_mux4_arbiter.sv
// Self-checking bench for lzy_mux4_arbiter. A cycle-level model of the
// ownership rules (owner, cycles held, rotation pointer) predicts the outputs;
// directed sequences add literal expectations, and a behavioural 74HC153
// checks the closed-loop Y value.
module tb_lzy_mux4_arbiter;

  localparam int SLOT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       mux_e;
  logic [1:0] mux_s;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_owner;   // -1 when nobody owns the mux
  bit m_gap;
  int m_age;     // cycles the current owner has held the mux
  int m_ptr;
  int m_sel;

  logic [3:0] ch_data = 4'b1010;

  lzy_mux4_arbiter #(.SLOT_CYCLES(SLOT)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .mux_e (mux_e),
    .mux_s (mux_s),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [3:0] r);
    int p;
    logic [3:0] others;
    if (r_rst) begin
      m_owner = -1; m_gap = 1'b0; m_age = 0; m_ptr = 3; m_sel = 0;
    end else if (m_owner >= 0) begin
      others = r & ~(4'b0001 << m_owner);
      if (!r[m_owner] || (m_age >= SLOT && others != 4'b0000)) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      m_gap = 1'b0;
      p = rr_pick(r, m_ptr);
      if (p >= 0) begin
        m_owner = p; m_age = 1; m_sel = p;
      end
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic mux_y(input logic e, input logic [1:0] s);
    return e ? 1'b0 : ch_data[s];
  endfunction

  // Compare process: advance the model on each edge, check just after it.
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, req);
      #1;
      check("gnt",   32'(gnt),   32'(model_gnt()));
      check("mux_e", 32'(mux_e), 32'(m_owner < 0));
      check("mux_s", 32'(mux_s), 32'(m_sel));
      check("busy",  32'(busy),  32'(m_owner >= 0 || m_gap));
      check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv_gnt_e",   32'(gnt != 4'b0000), 32'(mux_e == 1'b0));
      if (gnt != 4'b0000) check("inv_gnt_sel", 32'(gnt[mux_s]), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         g_ch[16];
  int         g_start[16];
  int         g_len[16];
  int         n_g;
  logic [3:0] prev_gnt;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    cyc(2);
    check("reset_gnt",   32'(gnt),   32'h0);
    check("reset_mux_e", 32'(mux_e), 32'h1);
    check("reset_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    cyc(1);

    // single request, grant after one edge, then release through one GAP
    req = 4'b0100;
    cyc(1);
    check("t2_gnt",   32'(gnt),   32'h4);
    check("t2_mux_s", 32'(mux_s), 32'h2);
    check("t2_mux_e", 32'(mux_e), 32'h0);
    req = 4'b0000;
    cyc(1);
    check("t2_gap_gnt",  32'(gnt),   32'h0);
    check("t2_gap_e",    32'(mux_e), 32'h1);
    check("t2_gap_busy", 32'(busy),  32'h1);
    cyc(1);
    check("t2_idle_busy", 32'(busy), 32'h0);

    // asynchronous reset in the middle of a grant
    req = 4'b0100;
    cyc(1);
    check("t1_pre_gnt", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    check("t1_gnt",   32'(gnt),   32'h0);
    check("t1_mux_e", 32'(mux_e), 32'h1);
    check("t1_mux_s", 32'(mux_s), 32'h0);
    check("t1_busy",  32'(busy),  32'h0);
    cyc(1);
    rst = 1'b0;
    req = 4'b0000;
    cyc(3);

    // lone requester keeps the mux past its slot
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("t4_hold", 32'(gnt), 32'h2);
    end
    req = 4'b0000;
    cyc(3);

    // release and immediate re-request: ch3 wins, ch0 follows
    req = 4'b0001;
    cyc(1);
    check("t5_ch0", 32'(gnt), 32'h1);
    req = 4'b1001;
    cyc(1);
    req = 4'b1000;
    cyc(1);
    check("t5_gap", 32'(gnt), 32'h0);
    req = 4'b1001;
    for (int i = 0; i < SLOT; i++) begin
      cyc(1);
      check("t5_ch3", 32'(gnt), 32'h8);
    end
    cyc(1);
    check("t5_gap2", 32'(gnt), 32'h0);
    cyc(1);
    check("t5_ch0_back", 32'(gnt), 32'h1);
    req = 4'b0000;
    cyc(3);

    // full contention with the mux in the loop
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b1111;
    n_g = 0;
    prev_gnt = 4'b0000;
    for (int c = 0; c < 80; c++) begin
      cyc(1);
      check("t6_y", 32'(mux_y(mux_e, mux_s)),
            32'((m_owner >= 0) ? ch_data[m_owner] : 1'b0));
      if (gnt != 4'b0000 && prev_gnt == 4'b0000 && n_g < 16) begin
        for (int k = 0; k < 4; k++) if (gnt[k]) g_ch[n_g] = k;
        g_start[n_g] = c;
        g_len[n_g]   = 0;
        n_g++;
      end
      if (gnt != 4'b0000 && n_g > 0) g_len[n_g-1]++;
      prev_gnt = gnt;
    end
    check("t3_n_grants", 32'(n_g >= 5), 32'd1);
    if (n_g >= 5) begin
      check("t3_order0", 32'(g_ch[0]), 32'd0);
      check("t3_order1", 32'(g_ch[1]), 32'd1);
      check("t3_order2", 32'(g_ch[2]), 32'd2);
      check("t3_order3", 32'(g_ch[3]), 32'd3);
      check("t3_order4", 32'(g_ch[4]), 32'd0);
      check("t3_period", 32'(g_start[4] - g_start[0]), 32'd36);
      for (int k = 0; k < 4; k++) check("t3_slot_len", 32'(g_len[k]), 32'd8);
    end
    req = 4'b0000;
    cyc(3);
    check("end_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
